fb_port_arbiter: RTL and testbench

- Shares the single-port 1-bpp framebuffer RAM (640x480, 8 pixels per byte, 38400 bytes) between three requesters.
- Requesters, in priority order: the display scan-out reader (real-time), a framebuffer clear engine (internal FSM) and a generic pixel-byte writer (req/ack handshake).
- Sits between the framebuffer RAM and the display/overlay path; display read data feeds the overlay stage as IM_DATA.

---
 rtl/fb_port_arbiter_if.sv | 34 +++
 rtl/fb_port_arbiter.sv | 105 ++++++++++
 tb/tb_fb_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_port_arbiter_if.sv
// Bundle of requester, status and RAM-port signals around the framebuffer port arbiter.
// master = requesters plus the RAM read path, slave = the arbiter itself.
interface fb_port_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              DISP_REQ;
  logic [ADDR_W-1:0] DISP_ADDR;
  logic              DISP_VALID;
  logic [7:0]        DISP_DATA;
  logic              WR_REQ;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [7:0]        WR_DATA;
  logic              WR_ACK;
  logic              WR_STARVE;
  logic              CLR_START;
  logic              CLR_BUSY;
  logic              CLR_DONE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [7:0]        MEM_WDATA;
  logic              MEM_WE;
  logic [7:0]        MEM_RDATA;

  modport master (
    output DISP_REQ, DISP_ADDR, WR_REQ, WR_ADDR, WR_DATA, CLR_START, MEM_RDATA,
    input  DISP_VALID, DISP_DATA, WR_ACK, WR_STARVE, CLR_BUSY, CLR_DONE,
           MEM_ADDR, MEM_WDATA, MEM_WE
  );

  modport slave (
    input  DISP_REQ, DISP_ADDR, WR_REQ, WR_ADDR, WR_DATA, CLR_START, MEM_RDATA,
    output DISP_VALID, DISP_DATA, WR_ACK, WR_STARVE, CLR_BUSY, CLR_DONE,
           MEM_ADDR, MEM_WDATA, MEM_WE
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer RAM arbiter: display scan-out > clear engine > byte writer.
//   state | meaning
//   IDLE  | no clear running; non-display slots go to the writer
//   CLEAR | sweeping 0..FB_BYTES-1 with CLEAR_VALUE; writer blocked
module fb_port_arbiter #(
  parameter int         ADDR_W      = 16,
  parameter int         FB_BYTES    = 38400,
  parameter int         RD_LAT      = 1,
  parameter logic [7:0] CLEAR_VALUE = 8'h00,
  parameter int         WR_WAIT_MAX = 1023
) (
  input logic              CLOCK_50,
  input logic              RESET,
  fb_port_arbiter_if.slave bus
);

  localparam int                CNT_W    = $clog2(WR_WAIT_MAX + 2);
  localparam logic [CNT_W-1:0]  WAIT_SAT = CNT_W'(WR_WAIT_MAX + 1);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_BYTES - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_nxt;
  logic [RD_LAT:0]   rd_pipe;
  logic              clr_slot;
  logic              clr_last;
  logic              clr_launch;
  logic              wr_slot;

  always_comb begin
    clr_slot   = !bus.DISP_REQ && (state == CLEAR);
    clr_last   = clr_slot && (clr_cnt == CLR_LAST);
    clr_launch = (state == IDLE) && bus.CLR_START;
    // a clear launched on this edge already owns the writer's slot
    wr_slot    = !bus.DISP_REQ && (state == IDLE) && !bus.CLR_START && bus.WR_REQ;
    wait_nxt   = wait_cnt;
    if (!bus.WR_REQ || wr_slot)
      wait_nxt = '0;
    else if (wait_cnt != WAIT_SAT)
      wait_nxt = wait_cnt + 1'b1;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      state          <= IDLE;
      clr_cnt        <= '0;
      wait_cnt       <= '0;
      rd_pipe        <= '0;
      bus.MEM_ADDR   <= '0;
      bus.MEM_WDATA  <= '0;
      bus.MEM_WE     <= 1'b0;
      bus.DISP_VALID <= 1'b0;
      bus.DISP_DATA  <= '0;
      bus.WR_ACK     <= 1'b0;
      bus.WR_STARVE  <= 1'b0;
      bus.CLR_BUSY   <= 1'b0;
      bus.CLR_DONE   <= 1'b0;
    end else begin
      bus.MEM_WE   <= 1'b0;
      bus.WR_ACK   <= 1'b0;
      bus.CLR_DONE <= 1'b0;

      if (bus.DISP_REQ) begin
        bus.MEM_ADDR <= bus.DISP_ADDR;
      end else if (clr_slot) begin
        bus.MEM_ADDR  <= clr_cnt;
        bus.MEM_WDATA <= CLEAR_VALUE;
        bus.MEM_WE    <= 1'b1;
        if (clr_last) begin
          state        <= IDLE;
          clr_cnt      <= '0;
          bus.CLR_BUSY <= 1'b0;
          bus.CLR_DONE <= 1'b1;
        end else begin
          clr_cnt <= clr_cnt + 1'b1;
        end
      end else if (wr_slot) begin
        bus.MEM_ADDR  <= bus.WR_ADDR;
        bus.MEM_WDATA <= bus.WR_DATA;
        bus.MEM_WE    <= 1'b1;
        bus.WR_ACK    <= 1'b1;
      end

      if (clr_launch) begin
        state        <= CLEAR;
        clr_cnt      <= '0;
        bus.CLR_BUSY <= 1'b1;
      end

      // rd_pipe[i] marks a read whose address left the arbiter i edges ago
      rd_pipe        <= {rd_pipe[RD_LAT-1:0], bus.DISP_REQ};
      bus.DISP_VALID <= rd_pipe[RD_LAT];
      if (rd_pipe[RD_LAT])
        bus.DISP_DATA <= bus.MEM_RDATA;

      wait_cnt <= wait_nxt;
      if (wait_nxt == WAIT_SAT)
        bus.WR_STARVE <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: RAM model, display read scoreboard,
// table-driven writer-vs-display vectors and hand-written clear/reset/starvation sequences.
module tb_fb_port_arbiter;
  localparam int ADDR_W   = 16;
  localparam int FB_BYTES = 38400;
  localparam int RD_LAT   = 1;
  localparam int WMAX     = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fb_port_arbiter_if #(.ADDR_W(ADDR_W)) bus();

  fb_port_arbiter #(
    .ADDR_W(ADDR_W), .FB_BYTES(FB_BYTES), .RD_LAT(RD_LAT),
    .CLEAR_VALUE(8'h00), .WR_WAIT_MAX(WMAX)
  ) dut (
    .CLOCK_50(clk),
    .RESET(rst_n),
    .bus(bus)
  );

  logic [7:0] ram     [FB_BYTES];
  logic [7:0] ref_mem [FB_BYTES];
  logic [7:0] rstage  [RD_LAT];

  always @(posedge clk) begin
    if (bus.MEM_WE && int'(bus.MEM_ADDR) < FB_BYTES) ram[bus.MEM_ADDR] <= bus.MEM_WDATA;
    rstage[0] <= (int'(bus.MEM_ADDR) < FB_BYTES) ? ram[bus.MEM_ADDR] : 8'h00;
    for (int i = 1; i < RD_LAT; i++) rstage[i] <= rstage[i-1];
  end
  assign bus.MEM_RDATA = rstage[RD_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         due;
  } rd_t;
  rd_t sbq[$];
  rd_t head;

  always @(posedge clk) begin
    #1;
    if (bus.DISP_VALID) begin
      if (sbq.size() == 0) begin
        check("disp_unexpected_valid", bus.DISP_VALID, 1'b0);
      end else begin
        head = sbq.pop_front();
        check("disp_data", bus.DISP_DATA, head.data);
        check("disp_latency", cyc, head.due);
      end
    end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      check("disp_valid_missing", cyc, sbq[0].due - 1);
      void'(sbq.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_disp(input bit en, input logic [15:0] a);
    bus.DISP_REQ  = en;
    bus.DISP_ADDR = a;
    if (en) sbq.push_back('{data: ref_mem[int'(a)], due: cyc + 2 + RD_LAT});
  endtask

  task automatic idle_inputs();
    bus.DISP_REQ  = 1'b0;
    bus.DISP_ADDR = '0;
    bus.WR_REQ    = 1'b0;
    bus.WR_ADDR   = '0;
    bus.WR_DATA   = '0;
    bus.CLR_START = 1'b0;
  endtask

  task automatic drain();
    repeat (RD_LAT + 4) tick();
  endtask

  task automatic check_all_zero(input string name);
    check(name, {bus.MEM_ADDR, bus.MEM_WDATA, bus.MEM_WE, bus.DISP_VALID, bus.DISP_DATA,
                 bus.WR_ACK, bus.WR_STARVE, bus.CLR_BUSY, bus.CLR_DONE}, 64'h0);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          hold;
    bit          starve;
  } wr_vec_t;
  wr_vec_t vec[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acked, we_seen, found, done_seen;
    int bad, clr_exp;
    logic [7:0] v;

    vec[0] = '{16'h0100, 8'h11, 0,  1'b0};
    vec[1] = '{16'h0200, 8'h22, 3,  1'b0};
    vec[2] = '{16'h0300, 8'h33, 7,  1'b0};
    vec[3] = '{16'h1234, 8'h5A, 10, 1'b1};

    for (int a = 0; a < FB_BYTES; a++) begin
      v = 8'(a) ^ 8'(a >> 8) ^ 8'h5C;
      ram[a] = v;
      ref_mem[a] = v;
    end
    ram[16] = 8'hA5;
    ref_mem[16] = 8'hA5;

    // reset held with random inputs
    idle_inputs();
    rst_n = 1'b0;
    repeat (5) begin
      bus.DISP_REQ  = 1'($urandom);
      bus.DISP_ADDR = 16'($urandom_range(0, FB_BYTES - 1));
      bus.WR_REQ    = 1'($urandom);
      bus.WR_ADDR   = 16'($urandom);
      bus.WR_DATA   = 8'($urandom);
      bus.CLR_START = 1'($urandom);
      tick();
    end
    check_all_zero("reset_outputs");
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();

    // first read after reset
    drive_disp(1'b1, 16'h0010);
    tick();
    drive_disp(1'b0, 16'h0);
    drain();

    // back-to-back display burst
    we_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive_disp(1'b1, 16'(i));
      tick();
      we_seen |= bus.MEM_WE;
    end
    drive_disp(1'b0, 16'h0);
    drain();
    check("burst_no_mem_we", we_seen, 1'b0);

    // writer vs display table
    for (int r = 0; r < 4; r++) begin
      bus.WR_REQ  = 1'b1;
      bus.WR_ADDR = vec[r].addr;
      bus.WR_DATA = vec[r].data;
      acked = 1'b0;
      for (int n = 1; n <= vec[r].hold + 6 && !acked; n++) begin
        drive_disp(n <= vec[r].hold, 16'h0040 + 16'(n));
        tick();
        if (bus.WR_ACK) begin
          acked = 1'b1;
          check("wr_ack_edge", n, vec[r].hold + 1);
          check("wr_mem_port", {bus.MEM_WE, bus.MEM_ADDR, bus.MEM_WDATA},
                {1'b1, vec[r].addr, vec[r].data});
          check("wr_starve_flag", bus.WR_STARVE, vec[r].starve);
          ref_mem[int'(vec[r].addr)] = vec[r].data;
          bus.WR_REQ = 1'b0;
        end
      end
      check("wr_ack_seen", acked, 1'b1);
      drive_disp(1'b0, 16'h0);
      bus.WR_REQ = 1'b0;
      tick();
      check("wr_ack_one_cycle", bus.WR_ACK, 1'b0);
    end
    for (int r = 0; r < 4; r++) begin
      drive_disp(1'b1, vec[r].addr);
      tick();
    end
    drive_disp(1'b0, 16'h0);
    drain();

    // starvation after a fresh reset
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_clears_starve");
    tick();
    rst_n = 1'b1;
    tick();
    bus.WR_REQ  = 1'b1;
    bus.WR_ADDR = 16'h2000;
    bus.WR_DATA = 8'h77;
    acked = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      drive_disp(1'b1, 16'h0060 + 16'(n));
      tick();
      acked |= bus.WR_ACK;
      if (n == 7) check("starve_after_7", bus.WR_STARVE, 1'b0);
      if (n == 8) check("starve_after_8", bus.WR_STARVE, 1'b1);
    end
    check("no_ack_under_display", acked, 1'b0);
    drive_disp(1'b0, 16'h0);
    tick();
    check("starve_ack", {bus.WR_ACK, bus.MEM_ADDR, bus.WR_STARVE}, {1'b1, 16'h2000, 1'b1});
    ref_mem[16'h2000] = 8'h77;
    bus.WR_REQ = 1'b0;
    repeat (3) tick();
    check("starve_sticky", bus.WR_STARVE, 1'b1);
    drain();

    // full-frame clear with a display steal, ignored restart and blocked writer
    bus.CLR_START = 1'b1;
    tick();
    bus.CLR_START = 1'b0;
    check("clr_start_busy", {bus.CLR_BUSY, bus.MEM_WE}, {1'b1, 1'b0});
    clr_exp = 0;
    bad = 0;
    done_seen = 1'b0;
    for (int j = 1; j <= FB_BYTES + 10 && !done_seen; j++) begin
      bus.CLR_START = (j == 100);
      if (j == 200) begin
        bus.WR_REQ  = 1'b1;
        bus.WR_ADDR = 16'h0500;
        bus.WR_DATA = 8'hC3;
      end
      drive_disp(j == 300, 16'd37000);
      tick();
      if (j == 300) begin
        if (bus.MEM_WE !== 1'b0 || bus.MEM_ADDR !== 16'd37000) bad++;
      end else begin
        if (!(bus.MEM_WE === 1'b1 && int'(bus.MEM_ADDR) == clr_exp && bus.MEM_WDATA === 8'h00)) bad++;
        clr_exp++;
      end
      if (bus.WR_ACK) bad++;
      if (clr_exp == FB_BYTES) begin
        done_seen = 1'b1;
        check("clr_done_pulse", {bus.CLR_DONE, bus.CLR_BUSY}, {1'b1, 1'b0});
      end else if (bus.CLR_DONE || !bus.CLR_BUSY) begin
        bad++;
      end
    end
    bus.CLR_START = 1'b0;
    drive_disp(1'b0, 16'h0);
    check("clr_sequence_errors", bad, 0);
    check("clr_write_count", clr_exp, FB_BYTES);
    tick();
    check("wr_after_clear", {bus.WR_ACK, bus.MEM_WE, bus.MEM_ADDR, bus.MEM_WDATA},
          {1'b1, 1'b1, 16'h0500, 8'hC3});
    check("clr_done_one_cycle", bus.CLR_DONE, 1'b0);
    bus.WR_REQ = 1'b0;
    for (int a = 0; a < FB_BYTES; a++) ref_mem[a] = 8'h00;
    ref_mem[16'h0500] = 8'hC3;
    tick();
    drive_disp(1'b1, 16'h0000);     tick();
    drive_disp(1'b1, 16'h0500);     tick();
    drive_disp(1'b1, 16'd37399);    tick();
    drive_disp(1'b1, 16'd37000);    tick();
    drive_disp(1'b0, 16'h0);
    drain();

    // reset in the middle of a clear
    bus.CLR_START = 1'b1;
    tick();
    bus.CLR_START = 1'b0;
    found = 1'b0;
    for (int j = 0; j < 1100 && !found; j++) begin
      tick();
      if (bus.MEM_WE && bus.MEM_ADDR == 16'd1000) found = 1'b1;
    end
    check("clr_reached_1000", found, 1'b1);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_clear");
    done_seen = 1'b0;
    repeat (3) begin
      tick();
      done_seen |= bus.CLR_DONE | bus.CLR_BUSY;
    end
    check("no_done_after_abort", done_seen, 1'b0);
    rst_n = 1'b1;
    tick();
    bus.CLR_START = 1'b1;
    tick();
    bus.CLR_START = 1'b0;
    check("restart_busy", bus.CLR_BUSY, 1'b1);
    tick();
    check("restart_addr0", {bus.MEM_WE, bus.MEM_ADDR, bus.MEM_WDATA}, {1'b1, 16'h0000, 8'h00});
    tick();
    check("restart_addr1", {bus.MEM_WE, bus.MEM_ADDR}, {1'b1, 16'h0001});
    rst_n = 1'b0;
    drain();
    check("scoreboard_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
